mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns byte/halfword/word load and store commands into
// accesses on a word-wide RAM with combinational read data. Sub-word stores
// use read-modify-write. Loads are lane-selected (little-endian) and
// zero- or sign-extended.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   req_valid / req_ready       command handshake (req_ready only in IDLE)
//   req_we, req_size, req_sign  store/load, 00 byte 01 half 10 word, load sign
//   req_addr, req_wdata         byte address, right-aligned store data
//   rsp_valid / rsp_ready       response handshake
//   rsp_rdata, rsp_err          extended load data (0 for stores), reject flag
//   mem_address                 word-aligned RAM byte address
//   mem_data_write              RAM write data
//   mem_write_en, mem_read_en   RAM strobes
//   mem_data_in                 RAM combinational read data
//   state_dbg                   current FSM state encoding
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The response side holds rsp_valid, rsp_rdata and rsp_err stable
// until rsp_ready is seen; req_valid is ignored outside IDLE.
//
// Build option: define MEM_ACCESS_BOUNDS_EN to reject addresses at or above
// 4*MEM_WORDS bytes. Without it every address is passed through unchanged.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        STORE  = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Latched command
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic [DATA_W-1:0] rdata_q;   // extended load result, 0 for stores
    logic [DATA_W-1:0] rmw_q;     // word captured in RMW_RD

    logic              accept;
    logic              cmd_err;
    logic              out_of_range;
    logic [4:0]        lane_shift;
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] merged;

    assign state_dbg = state;
    assign accept    = (state == IDLE) && req_valid;

`ifdef MEM_ACCESS_BOUNDS_EN
    assign out_of_range = (req_addr >= 32'(4 * MEM_WORDS));
`else
    assign out_of_range = 1'b0;
`endif

    // Legality is judged on the live request in the accept cycle.
    assign cmd_err = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                   || out_of_range;

    assign lane_shift = {addr_q[1:0], 3'b000};
    assign lane_data  = mem_data_in >> lane_shift;

    always_comb begin
        load_ext = lane_data;
        case (size_q)
            2'b00: load_ext = sign_q ? {{(DATA_W-8){lane_data[7]}}, lane_data[7:0]}
                                     : {{(DATA_W-8){1'b0}}, lane_data[7:0]};
            2'b01: load_ext = sign_q ? {{(DATA_W-16){lane_data[15]}}, lane_data[15:0]}
                                     : {{(DATA_W-16){1'b0}}, lane_data[15:0]};
            default: load_ext = lane_data;
        endcase
    end

    // Only the addressed byte/halfword lane is replaced in the captured word.
    assign lane_mask = ((size_q == 2'b00) ? DATA_W'(8'hFF) : DATA_W'(16'hFFFF)) << lane_shift;
    assign merged    = (rmw_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rmw_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                sign_q  <= req_sign;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= cmd_err;
                rdata_q <= '0;
            end
            if (state == LOAD)   rdata_q <= load_ext;
            if (state == RMW_RD) rmw_q   <= mem_data_in;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (cmd_err)                state_nxt = RESP;
                    else if (!req_we)           state_nxt = LOAD;
                    else if (req_size == 2'b10) state_nxt = STORE;
                    else                        state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = RESP;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = RESP;
            STORE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while reset is high so an aborted command
    // cannot strobe the RAM in the reset cycle.
    always_comb begin
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
        rsp_err        = 1'b0;
        mem_address    = '0;
        mem_data_write = '0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: req_ready = 1'b1;
                LOAD: begin
                    mem_read_en = 1'b1;
                    mem_address = {addr_q[31:2], 2'b00};
                end
                RMW_RD: begin
                    mem_read_en = 1'b1;
                    mem_address = {addr_q[31:2], 2'b00};
                end
                RMW_WR: begin
                    mem_write_en   = 1'b1;
                    mem_address    = {addr_q[31:2], 2'b00};
                    mem_data_write = merged;
                end
                STORE: begin
                    mem_write_en   = 1'b1;
                    mem_address    = {addr_q[31:2], 2'b00};
                    mem_data_write = wdata_q;
                end
                RESP: begin
                    rsp_valid = 1'b1;
                    rsp_rdata = rdata_q;
                    rsp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int MEM_WORDS = 32;
    localparam int DATA_W    = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              req_valid, req_ready, req_we, req_sign;
    logic [1:0]        req_size;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [31:0]       mem_address;
    logic [DATA_W-1:0] mem_data_write, mem_data_in;
    logic              mem_write_en, mem_read_en;
    logic [2:0]        state_dbg;

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_address(mem_address),
        .mem_data_write(mem_data_write), .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en), .mem_data_in(mem_data_in), .state_dbg(state_dbg)
    );

    // ---------------- RAM model and strobe counters ----------------
    logic [31:0] ram [MEM_WORDS];
    logic [31:0] shadow [MEM_WORDS];
    int wr_cnt = 0;
    int rd_cnt = 0;

    assign mem_data_in = ram[mem_address[6:2]];

    always @(posedge clk) begin
        if (mem_write_en) ram[mem_address[6:2]] <= mem_data_write;
    end
    always @(posedge clk) begin
        if (mem_write_en) wr_cnt++;
        if (mem_read_en)  rd_cnt++;
    end

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];   // {err, rdata}
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        if (size == 2'b00) return sgn ? {{24{b[7]}}, b} : {24'h0, b};
        if (size == 2'b01) return sgn ? {{16{h[15]}}, h} : {16'h0, h};
        return w;
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (size == 2'b10) r = d;
        else if (size == 2'b01) begin
            if (off[1]) r[31:16] = d[15:0];
            else        r[15:0]  = d[15:0];
        end else begin
            case (off)
                2'd0: r[7:0]   = d[7:0];
                2'd1: r[15:8]  = d[7:0];
                2'd2: r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // Entered and left at a falling edge with the DUT idle.
    task automatic do_cmd(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_lat, input int exp_rd, input int exp_wr,
                          input int hold);
        int lat;
        int rd0, wr0;
        logic [32:0] e;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sgn;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back({exp_err, exp_rdata});
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1;
        // Garbage command held valid while busy: must be ignored.
        req_we    = 1'($urandom_range(0, 1));
        req_size  = 2'($urandom_range(0, 3));
        req_sign  = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !exp_err)
                check("mem_address", mem_address, {addr[31:2], 2'b00});
            if (rsp_valid) break;
            if (lat >= 16) break;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", rsp_valid, 1);
            void'(exp_q.pop_front());
            req_valid = 1'b0;
            return;
        end
        check("latency", lat, exp_lat);
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, e[31:0]);
        end
        check("rsp_err", rsp_err, e[32]);
        check("rsp_rdata", rsp_rdata, e[31:0]);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_drop", rsp_valid, 0);
        check("read_cycles", rd_cnt - rd0, exp_rd);
        check("write_pulses", wr_cnt - wr0, exp_wr);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_wr_en"}, mem_write_en, 0);
        check({tag, "_rd_en"}, mem_read_en, 0);
        check({tag, "_rdata"}, rsp_rdata, 0);
        check({tag, "_maddr"}, mem_address, 0);
        check({tag, "_mwdata"}, mem_data_write, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wr0;
        logic [1:0]  sz, off;
        logic        we, sg;
        int          idx;
        logic [31:0] wd, ex;

        for (int i = 0; i < MEM_WORDS; i++) begin
            ram[i]    = 32'h1357_9BDF ^ (i * 32'h0101_0101);
            shadow[i] = ram[i];
        end
        ram[3]  = 32'h0000_000C;  shadow[3]  = 32'h0000_000C;
        ram[14] = 32'hF000_0000;  shadow[14] = 32'hF000_0000;
        ram[12] = 32'h0000_0007;  shadow[12] = 32'h0000_0007;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // word load
        do_cmd(0, 2'b10, 0, 32'h0C, 0, 0, 32'h0000_000C, 2, 1, 0, 0);
        // byte loads, sign and zero extension
        do_cmd(0, 2'b00, 1, 32'h3B, 0, 0, 32'hFFFF_FFF0, 2, 1, 0, 0);
        do_cmd(0, 2'b00, 0, 32'h3B, 0, 0, 32'h0000_00F0, 2, 1, 0, 0);
        // halfword store via read-modify-write
        do_cmd(1, 2'b01, 0, 32'h32, 32'h1234_ABCD, 0, 0, 3, 1, 1, 0);
        shadow[12] = 32'hABCD_0007;
        check("ram12_after_hstore", ram[12], 32'hABCD_0007);
        do_cmd(0, 2'b10, 0, 32'h30, 0, 0, 32'hABCD_0007, 2, 1, 0, 0);
        // rejected commands
        do_cmd(0, 2'b10, 0, 32'h06, 0, 1, 0, 1, 0, 0, 0);
        do_cmd(0, 2'b11, 0, 32'h04, 0, 1, 0, 1, 0, 0, 0);
        do_cmd(1, 2'b01, 0, 32'h21, 32'hFFFF, 1, 0, 1, 0, 0, 0);
        do_cmd(1, 2'b10, 0, 32'h22, 32'hDEAD_BEEF, 1, 0, 1, 0, 0, 0);
        check("ram8_untouched", ram[8], shadow[8]);
        // word store then read back
        do_cmd(1, 2'b10, 0, 32'h14, 32'hCAFE_F00D, 0, 0, 2, 0, 1, 0);
        shadow[5] = 32'hCAFE_F00D;
        do_cmd(0, 2'b01, 1, 32'h16, 0, 0, 32'hFFFF_CAFE, 2, 1, 0, 0);

        // address 0x80 with response held for 3 cycles
`ifdef MEM_ACCESS_BOUNDS_EN
        do_cmd(0, 2'b10, 0, 32'h80, 0, 1, 0, 1, 0, 0, 3);
`else
        do_cmd(0, 2'b10, 0, 32'h80, 0, 0, shadow[0], 2, 1, 0, 3);
`endif

        // random sub-word/word traffic against the shadow model
        for (int i = 0; i < 12; i++) begin
            sz  = 2'($urandom_range(0, 2));
            idx = $urandom_range(16, 31);
            off = (sz == 2'b00) ? 2'($urandom_range(0, 3)) :
                  (sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            we  = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (we) begin
                shadow[idx] = st_model(shadow[idx], off, sz, wd);
                do_cmd(1, sz, sg, {idx[29:0], off}, wd, 0, 0,
                       (sz == 2'b10) ? 2 : 3, (sz == 2'b10) ? 0 : 1, 1, 0);
            end else begin
                ex = ld_model(shadow[idx], off, sz, sg);
                do_cmd(0, sz, sg, {idx[29:0], off}, wd, 0, ex, 2, 1, 0, i % 3);
            end
        end
        for (int i = 16; i < MEM_WORDS; i++) check("ram_final", ram[i], shadow[i]);

        // reset during RMW_RD of a byte store
        wr0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_quiet("mid_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_abort", req_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check("no_rsp_after_abort", rsp_valid, 0);
        end
        check("abort_write_pulses", wr_cnt - wr0, 0);
        check("ram8_after_abort", ram[8], shadow[8]);

        // still functional afterwards
        do_cmd(0, 2'b00, 0, 32'h21, 0, 0, ld_model(shadow[8], 2'd1, 2'b00, 0), 2, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
